// File: rtl/lsu_mem_port_if.sv
// Core-side request/response channel and data-memory bus of the load/store unit.
// master: the LSU itself; slave: the core plus memory environment.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: alignment/legality checks, store lane steering, load extension and a
// req/gnt/rvalid bus handshake with timeout. One request outstanding at a time.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_port_if.master bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             req_err;
    logic             timeout;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    // Legality and alignment of the incoming request, evaluated only in StIdle.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_op)
            3'b000:         req_err = 1'b0;
            3'b001, 3'b101: req_err = bus.req_addr[0] | (bus.req_wr & bus.req_op[2]);
            3'b010:         req_err = |bus.req_addr[1:0];
            3'b100:         req_err = bus.req_wr;
            default:        req_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (op_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // >= so a grant on the expiry cycle still times out in StWait unless rvalid arrives
        timeout = (cnt_q >= CntLast);

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? StResp : StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_gnt) begin
                    state_d = StWait;
                end else if (timeout) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_rvalid) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? 32'h0 : ld_data;
                end else if (timeout) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode registered state only.
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_rdata = (state_q == StResp) ? rdata_q : 32'h0;
        bus.resp_err   = (state_q == StResp) & err_q;
        bus.mem_req    = (state_q == StIssue);
        bus.mem_we     = (state_q == StIssue) & wr_q;
        bus.mem_addr   = {addr_q[31:2], 2'b00};
        bus.mem_wdata  = wdata_q;
        bus.mem_wmask  = 4'b0000;
        if (wr_q) begin
            case (op_q[1:0])
                2'b00: begin
                    bus.mem_wdata = {4{wdata_q[7:0]}};
                    bus.mem_wmask = 4'b0001 << addr_q[1:0];
                end
                2'b01: begin
                    bus.mem_wdata = {2{wdata_q[15:0]}};
                    bus.mem_wmask = 4'b0011 << addr_q[1:0];
                end
                default: bus.mem_wmask = 4'b1111;
            endcase
        end
        if (state_q != StIssue) begin
            bus.mem_wmask = 4'b0000;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: expected bus beats and responses are queued at drive
// time and popped by negedge monitors when the DUT presents them.
module tb_lsu_mem_port;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_req = 0;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    lsu_mem_port_if bus ();

    lsu_mem_port #(
        .TIMEOUT(8),
        .CNT_W  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_req) n_req++;
    end

    always @(negedge clk) begin
        bus_exp_t b;
        if (!rst && bus.mem_req && bus.mem_gnt) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 32'd1, 32'd0);
            end else begin
                b = bus_q.pop_front();
                chk("bus_addr", bus.mem_addr, b.addr);
                chk("bus_we", {31'd0, bus.mem_we}, {31'd0, b.we});
                chk("bus_wmask", {28'd0, bus.mem_wmask}, {28'd0, b.mask});
                if (b.we) chk("bus_wdata", bus.mem_wdata, b.wdata);
            end
        end
    end

    always @(negedge clk) begin
        resp_exp_t r;
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                r = resp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, r.rdata);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, r.err});
            end
        end
    end

    // Called at posedge+1 with the DUT idle; gnt_dly < 0 means the bus never grants.
    task automatic txn(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int gnt_dly, input int rv_dly, input int rdy_dly,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
                       input int exp_lat, input int exp_reqs);
        int        cyc;
        int        req0;
        bit        found;
        bus_exp_t  b;
        resp_exp_t r;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        resp_q.push_back(r);
        if (!exp_err) begin
            b.addr  = {addr[31:2], 2'b00};
            b.we    = wr;
            b.wdata = exp_wdata;
            b.mask  = exp_mask;
            bus_q.push_back(b);
        end
        req0 = n_req;
        bus.resp_ready = (rdy_dly == 0);
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 1;
        if (gnt_dly >= 0) begin
            repeat (gnt_dly) begin @(posedge clk); #1; cyc++; end
            bus.mem_gnt = 1'b1;
            @(posedge clk); #1; cyc++;
            bus.mem_gnt = 1'b0;
            repeat (rv_dly) begin @(posedge clk); #1; cyc++; end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(posedge clk); #1; cyc++;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
        end
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1; cyc++;
        end
        chk("resp_seen", {31'd0, found}, 32'd1);
        if (!found) return;
        if (exp_lat >= 0) chk("latency", cyc, exp_lat);
        for (int k = 0; k < rdy_dly; k++) begin
            chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("hold_rdata", bus.resp_rdata, exp_rdata);
            chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
            if (k == rdy_dly - 1) bus.resp_ready = 1'b1;
            @(negedge clk);
        end
        chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
        chk("valid_after", {31'd0, bus.resp_valid}, 32'd0);
        chk("mem_req_cycles", n_req - req0, exp_reqs);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while a load sits in the issue state without a grant.
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_op    = 3'b010;
        bus.req_addr  = 32'h0000_0100;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("issue_mem_req", {31'd0, bus.mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //  wr  op      addr          wdata         rdata        g   rv rdy exp_rdata    err wdata_exp     mask     lat reqs
        txn(0, 3'b010, 32'h0000_5000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 32'h0,        4'b0000, 3, 1);
        txn(0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF1234, 0, 0, 0, 32'hFFFFFF80, 0, 32'h0,        4'b0000, 3, 1);
        txn(0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF1234, 0, 0, 0, 32'h00000080, 0, 32'h0,        4'b0000, 3, 1);
        txn(1, 3'b001, 32'h0000_2002, 32'h1234ABCD, 32'h0,        0, 0, 0, 32'h0,        0, 32'hABCDABCD, 4'b1100, 3, 1);
        txn(0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,       -1, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 1, 0);
        txn(1, 3'b100, 32'h0000_3000, 32'h55,       32'h0,       -1, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 1, 0);
        txn(1, 3'b101, 32'h0000_3000, 32'h55,       32'h0,       -1, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 1, 0);
        txn(0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,       -1, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 1, 0);
        txn(0, 3'b001, 32'h0000_4001, 32'h0,        32'h0,       -1, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 1, 0);
        // Bus never grants: eight issue cycles, then error.
        txn(0, 3'b010, 32'h0000_6000, 32'h0,        32'h0,       -1, 0, 0, 32'h0,        1, 32'h0,        4'b0000, 9, 8);

        // A stray rvalid while idle must not produce a response.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        @(negedge clk);
        chk("stray_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("stray_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;

        txn(0, 3'b101, 32'h0000_4002, 32'h0,        32'h9ABC0000, 0, 0, 5, 32'h00009ABC, 0, 32'h0,        4'b0000, 3, 1);
        txn(0, 3'b001, 32'h0000_4002, 32'h0,        32'h9ABC0000, 0, 0, 0, 32'hFFFF9ABC, 0, 32'h0,        4'b0000, 3, 1);
        txn(1, 3'b000, 32'h0000_1001, 32'h12345655, 32'h0,        0, 0, 0, 32'h0,        0, 32'h55555555, 4'b0010, 3, 1);
        txn(1, 3'b010, 32'h0000_7000, 32'hCAFEF00D, 32'h0,        2, 3, 0, 32'h0,        0, 32'hCAFEF00D, 4'b1111, 8, 3);
        // Grant on the last allowed cycle, rvalid next cycle: completion beats timeout.
        txn(0, 3'b010, 32'h0000_8000, 32'h0,        32'h11223344, 7, 0, 0, 32'h11223344, 0, 32'h0,        4'b0000, 10, 8);

        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting between the core's execute stage and the data-memory bus.
- Consumes the decoded memory controls: MemWr, plus MemOp, which carries the RV32I load/store func3.
- Performs address alignment checks, store byte-lane steering and masking, load extraction with sign/zero extension, and a req/gnt/rvalid bus handshake with timeout.
- Returns one response per accepted request to the core.

Parameters:
- TIMEOUT, 255: max cycles spent in ISSUE+WAIT before aborting with error; 1..65535.
- CNT_W, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a memory request.
- req_ready  out  1  LSU can accept a request.
- req_wr  in  1  1=store, 0=load (MemWr).
- req_op  in  3  MemOp/func3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  extended load data; 0 for stores/errors.
- resp_err  out  1  misaligned, illegal op, or timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte enables; 0000 on loads.
- mem_gnt  in  1  bus accepted request.
- mem_rvalid  in  1  read data valid / write ack.
- mem_rdata  in  32  read word.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Reset (async, any state, including mid-transaction): state=IDLE, timeout counter=0, all captured fields=0.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wmask=0.
  - An outstanding bus transaction is abandoned.
- IDLE:
  - req_ready=1.
  - On req_valid: capture wr/op/addr/wdata.
  - Error check:
    - op ∈ {011,110,111} → illegal.
    - Stores with op ∈ {100,101} → illegal.
    - Half op (x01) with addr[0]=1 → misaligned.
    - Word op (010) with addr[1:0]≠00 → misaligned.
  - On error → RESP with resp_err=1, resp_rdata=0; no bus activity.
  - Otherwise → ISSUE.
- ISSUE:
  - mem_req=1; mem_addr, mem_we, mem_wdata and mem_wmask are held stable until mem_gnt.
  - On mem_gnt → WAIT, and mem_req drops next cycle.
- Store steering:
  - sb: wdata={4{wdata[7:0]}}, mask=0001<<addr[1:0].
  - sh: wdata={2{wdata[15:0]}}, mask=0011<<addr[1:0].
  - sw: wdata unchanged, mask=1111.
- WAIT:
  - Await mem_rvalid; this is required for stores too, as the write ack.
  - A mem_rvalid arriving in the same cycle as mem_gnt (ISSUE) is NOT consumed; the bus must return it at least one cycle after gnt.
  - mem_rvalid outside WAIT is ignored.
- Load extraction, on rvalid:
  - Byte = mem_rdata[8*addr[1:0]+:8]; halfword = mem_rdata[16*addr[1]+:16].
  - op 000/001 sign-extend; 100/101 zero-extend; 010 passes the full word.
  - Result registered into resp_rdata; → RESP with resp_err=0.
- Timeout:
  - Counter clears on IDLE→ISSUE and increments each cycle in ISSUE or WAIT.
  - When counter == TIMEOUT-1 and no completing event occurs that cycle → RESP with resp_err=1, resp_rdata=0, mem_req dropped.
  - Completion on the same cycle as expiry wins over timeout.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_ready → IDLE; req_ready returns the next cycle (no same-cycle back-to-back accept).
- Throughput is 1 outstanding request. Best-case latency, with gnt in the first ISSUE cycle and rvalid the next cycle:
  - accept at cycle N;
  - mem_req N+1;
  - rvalid N+2;
  - resp_valid N+3.
- Error-path latency: resp_valid at N+1.

Test Plan:
- Reset mid-ISSUE (mem_req=1, no gnt) → the same cycle mem_req=0, req_ready=1; after release, a fresh lw completes normally.
- lb addr=0x1003, mem_rdata=0x80FF_1234 → mem_addr=0x1000, mem_wmask=0000, resp_rdata=0xFFFF_FF80, resp_err=0. Also lbu same → 0x0000_0080.
- sh addr=0x2002, wdata=0x1234_ABCD, gnt immediate, rvalid 1 cycle later → mem_we=1, mem_wdata=0xABCD_ABCD, mem_wmask=1100, resp_rdata=0, resp_valid at cycle N+3.
- lw addr=0x3001 → no mem_req ever asserted, resp_valid at N+1 with resp_err=1. Also sw with op=100 → illegal, err=1.
- TIMEOUT=8, mem_gnt held 0 → mem_req high for exactly 8 cycles, then resp_err=1, resp_rdata=0; a later stray mem_rvalid in IDLE is ignored.
- lhu addr=0x4002, mem_rdata=0x9ABC_0000, resp_ready held 0 for 5 cycles → resp_valid and resp_rdata=0x0000_9ABC stable throughout, req_ready=0 until the cycle after the handshake.
